overflow_monitor: RTL and testbench

Parametrised per-channel overflow monitor for the convolution datapath. It time-aligns adder overflow flags against multiplier overflow flags through a configurable delay line and combines them per channel under a selectable AND/OR mode. It records the result as registered per-cycle flags, sticky flags, a saturating event counter and a single-cycle interrupt pulse. It sits between the MAC array's status outputs and the coprocessor control/status registers.

---
 rtl/overflow_pkg.sv | 12 +
 rtl/overflow_delay_line.sv | 45 ++++
 rtl/overflow_monitor.sv | 110 +++++++++++
 tb/tb_overflow_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/overflow_pkg.sv
// Shared definitions for the overflow monitor.
//   MODE_AND / MODE_OR : encodings of the combine-mode select input.
//   MAX_CH             : largest supported channel count.
//   MAX_ADD_DELAY      : largest supported adder-flag alignment delay.
package overflow_pkg;

  localparam logic MODE_AND      = 1'b0;
  localparam logic MODE_OR       = 1'b1;
  localparam int   MAX_CH        = 32;
  localparam int   MAX_ADD_DELAY = 7;

endpackage : overflow_pkg

// File: rtl/overflow_delay_line.sv
// Fixed-depth flag delay line used to align adder overflow flags with the
// multiplier overflow flags.
// Parameters:
//   WIDTH : bits per stage
//   DEPTH : number of register stages; 0 makes the block a plain wire
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset, clears every stage
//   d     : flags entering the line
//   q     : flags delayed by DEPTH cycles
module overflow_delay_line
  import overflow_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Stage 0 captures d; each later stage takes the one before it.
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule : overflow_delay_line

// File: rtl/overflow_monitor.sv
// Per-channel overflow monitor for the convolution datapath.
// Adder overflow flags are delayed by ADD_DELAY cycles, combined with the
// multiplier overflow flags under AND/OR mode, and recorded as registered
// per-cycle flags, sticky flags, a saturating event counter and an irq pulse.
// Parameters:
//   NUM_CH    : channels monitored (1..32)
//   ADD_DELAY : alignment stages on ovf_add (0..7)
//   CNT_W     : event counter width (2..32)
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset
//   valid_in  : qualifies ovf_mul for the current cycle
//   ovf_add   : raw adder overflow per channel
//   ovf_mul   : multiplier overflow per channel
//   mode      : 0 = AND combine, 1 = OR combine
//   clear     : clears sticky flags and counter
//   ovf_out   : registered combined overflow per channel
//   sticky    : per-channel sticky flags
//   any_ovf   : OR of ovf_out, registered with it
//   ovf_count : saturating count of cycles with any combined overflow
//   irq       : one-cycle pulse when sticky goes from all-zero to non-zero
module overflow_monitor
  import overflow_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ADD_DELAY = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [NUM_CH-1:0] ovf_add,
  input  logic [NUM_CH-1:0] ovf_mul,
  input  logic              mode,
  input  logic              clear,
  output logic [NUM_CH-1:0] ovf_out,
  output logic [NUM_CH-1:0] sticky,
  output logic              any_ovf,
  output logic [CNT_W-1:0]  ovf_count,
  output logic              irq
);

  logic [NUM_CH-1:0] add_d;
  logic [NUM_CH-1:0] comb;
  logic              comb_any;

  logic [NUM_CH-1:0] ovf_q,    ovf_d;
  logic [NUM_CH-1:0] sticky_q, sticky_d;
  logic              any_q,    any_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              irq_q,    irq_d;
  logic [CNT_W-1:0]  cnt_base;

  overflow_delay_line #(
    .WIDTH (NUM_CH),
    .DEPTH (ADD_DELAY)
  ) u_add_dly (
    .clock (clock),
    .reset (reset),
    .d     (ovf_add),
    .q     (add_d)
  );

  always_comb begin
    comb     = '0;
    comb_any = 1'b0;
    if (valid_in) begin
      comb = (mode == MODE_OR) ? (add_d | ovf_mul) : (add_d & ovf_mul);
    end
    comb_any = |comb;
  end

  // Clear and a new event in the same cycle: the event survives, so the
  // clear is applied to the old state before the new bits are merged in.
  always_comb begin
    ovf_d    = comb;
    any_d    = comb_any;
    sticky_d = (clear ? '0 : sticky_q) | comb;
    cnt_base = clear ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (comb_any && (cnt_base != '1)) begin
      cnt_d = cnt_base + CNT_W'(1);
    end
    // A clear re-arms the interrupt even if sticky was non-zero before it.
    irq_d    = (|sticky_d) & ((~|sticky_q) | clear);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q    <= '0;
      any_q    <= 1'b0;
      sticky_q <= '0;
      cnt_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      ovf_q    <= ovf_d;
      any_q    <= any_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      irq_q    <= irq_d;
    end
  end

  assign ovf_out   = ovf_q;
  assign any_ovf   = any_q;
  assign sticky    = sticky_q;
  assign ovf_count = cnt_q;
  assign irq       = irq_q;

endmodule : overflow_monitor

// File: tb/tb_overflow_monitor.sv
module tb_overflow_monitor;
  import overflow_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [3:0] ovf_add;
  logic [3:0] ovf_mul;
  logic       mode;
  logic       clear;

  // a: defaults (ADD_DELAY=1, CNT_W=16)
  logic [3:0]  a_ovf, a_sticky;
  logic        a_any, a_irq;
  logic [15:0] a_cnt;
  // b: ADD_DELAY=0, CNT_W=2
  logic [3:0]  b_ovf, b_sticky;
  logic        b_any, b_irq;
  logic [1:0]  b_cnt;
  // c: ADD_DELAY=3
  logic [3:0]  c_ovf, c_sticky;
  logic        c_any, c_irq;
  logic [15:0] c_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  overflow_monitor #(.NUM_CH(4), .ADD_DELAY(1), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ovf_add(ovf_add),
    .ovf_mul(ovf_mul), .mode(mode), .clear(clear), .ovf_out(a_ovf),
    .sticky(a_sticky), .any_ovf(a_any), .ovf_count(a_cnt), .irq(a_irq));

  overflow_monitor #(.NUM_CH(4), .ADD_DELAY(0), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ovf_add(ovf_add),
    .ovf_mul(ovf_mul), .mode(mode), .clear(clear), .ovf_out(b_ovf),
    .sticky(b_sticky), .any_ovf(b_any), .ovf_count(b_cnt), .irq(b_irq));

  overflow_monitor #(.NUM_CH(4), .ADD_DELAY(3), .CNT_W(16)) dut_c (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ovf_add(ovf_add),
    .ovf_mul(ovf_mul), .mode(mode), .clear(clear), .ovf_out(c_ovf),
    .sticky(c_sticky), .any_ovf(c_any), .ovf_count(c_cnt), .irq(c_irq));

  typedef struct {
    logic [3:0] add;
    logic [3:0] mul;
    logic       vld;
    logic       md;
    logic       clr;
    logic [3:0] e_ovf;
    logic [3:0] e_sticky;
    logic       e_any;
    logic [1:0] e_cnt;
    logic       e_irq;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] add, input logic [3:0] mul,
                       input logic vld, input logic md, input logic clr);
    ovf_add  = add;
    ovf_mul  = mul;
    valid_in = vld;
    mode     = md;
    clear    = clr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(4'b0, 4'b0, 1'b0, MODE_AND, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int irq_seen;

    //              add      mul      v     md       clr   ovf      sticky   any   cnt    irq
    tbl[0]  = '{4'b0001, 4'b1000, 1'b1, MODE_OR,  1'b0, 4'b1001, 4'b1001, 1'b1, 2'd1, 1'b1};
    tbl[1]  = '{4'b0001, 4'b1000, 1'b0, MODE_OR,  1'b0, 4'b0000, 4'b1001, 1'b0, 2'd1, 1'b0};
    tbl[2]  = '{4'b0011, 4'b0010, 1'b1, MODE_AND, 1'b0, 4'b0010, 4'b1011, 1'b1, 2'd2, 1'b0};
    tbl[3]  = '{4'b0100, 4'b0010, 1'b1, MODE_AND, 1'b0, 4'b0000, 4'b1011, 1'b0, 2'd2, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0100, 1'b1, MODE_OR,  1'b0, 4'b0100, 4'b1111, 1'b1, 2'd3, 1'b0};
    tbl[5]  = '{4'b1111, 4'b0000, 1'b1, MODE_OR,  1'b0, 4'b1111, 4'b1111, 1'b1, 2'd3, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b1, MODE_OR,  1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{4'b0000, 4'b1000, 1'b1, MODE_OR,  1'b1, 4'b1000, 4'b1000, 1'b1, 2'd1, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, MODE_OR,  1'b0, 4'b0000, 4'b1000, 1'b0, 2'd1, 1'b0};
    tbl[9]  = '{4'b0000, 4'b0001, 1'b1, MODE_OR,  1'b1, 4'b0001, 4'b0001, 1'b1, 2'd1, 1'b1};
    tbl[10] = '{4'b0000, 4'b0001, 1'b1, MODE_AND, 1'b0, 4'b0000, 4'b0001, 1'b0, 2'd1, 1'b0};

    reset = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1, MODE_OR, 1'b0);
    step();
    chk("reset_ovf",    a_ovf,    0);
    chk("reset_sticky", a_sticky, 0);
    chk("reset_any",    a_any,    0);
    chk("reset_cnt",    a_cnt,    0);
    chk("reset_irq",    a_irq,    0);
    reset = 1'b0;

    // Table: ADD_DELAY=0, CNT_W=2 instance
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].add, tbl[i].mul, tbl[i].vld, tbl[i].md, tbl[i].clr);
      step();
      chk($sformatf("tbl%0d_ovf", i),    b_ovf,    tbl[i].e_ovf);
      chk($sformatf("tbl%0d_sticky", i), b_sticky, tbl[i].e_sticky);
      chk($sformatf("tbl%0d_any", i),    b_any,    tbl[i].e_any);
      chk($sformatf("tbl%0d_cnt", i),    b_cnt,    tbl[i].e_cnt);
      chk($sformatf("tbl%0d_irq", i),    b_irq,    tbl[i].e_irq);
    end

    // Alignment, ADD_DELAY=1, AND
    do_reset();
    drive(4'b0010, 4'b0000, 1'b0, MODE_AND, 1'b0);
    step();
    chk("align_c0_ovf", a_ovf, 0);
    drive(4'b0000, 4'b0010, 1'b1, MODE_AND, 1'b0);
    step();
    chk("align_ovf",    a_ovf,    4'b0010);
    chk("align_any",    a_any,    1);
    chk("align_sticky", a_sticky, 4'b0010);
    chk("align_cnt",    a_cnt,    1);
    chk("align_irq",    a_irq,    1);
    drive(4'b0000, 4'b0000, 1'b0, MODE_AND, 1'b0);
    step();
    chk("align_irq_once", a_irq, 0);
    chk("align_ovf_next", a_ovf, 0);

    // Misaligned: ovf_mul one cycle late
    do_reset();
    drive(4'b0010, 4'b0000, 1'b0, MODE_AND, 1'b0);
    step();
    drive(4'b0000, 4'b0000, 1'b0, MODE_AND, 1'b0);
    step();
    drive(4'b0000, 4'b0010, 1'b1, MODE_AND, 1'b0);
    step();
    chk("misalign_ovf", a_ovf, 0);
    chk("misalign_cnt", a_cnt, 0);

    // Sticky and irq
    do_reset();
    irq_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      drive(4'b0, 4'b0001, 1'b1, MODE_OR, 1'b0);
      else if (c == 3) drive(4'b0, 4'b0100, 1'b1, MODE_OR, 1'b0);
      else             drive(4'b0, 4'b0000, 1'b0, MODE_OR, 1'b0);
      step();
      if (a_irq) irq_seen++;
    end
    chk("sticky_two",     a_sticky, 4'b0101);
    chk("sticky_irq_cnt", irq_seen, 1);
    chk("sticky_evcnt",   a_cnt,    2);
    drive(4'b0, 4'b0000, 1'b0, MODE_OR, 1'b1);
    step();
    chk("clear_sticky", a_sticky, 0);
    chk("clear_cnt",    a_cnt,    0);
    chk("clear_irq",    a_irq,    0);
    drive(4'b0, 4'b1000, 1'b1, MODE_OR, 1'b1);
    step();
    chk("clrev_sticky", a_sticky, 4'b1000);
    chk("clrev_cnt",    a_cnt,    1);
    chk("clrev_irq",    a_irq,    1);

    // Counter saturation on CNT_W=2
    do_reset();
    drive(4'b0, 4'b0001, 1'b1, MODE_OR, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("sat%0d_cnt", c), b_cnt, (c < 3) ? c + 1 : 3);
    end

    // Reset mid-stream, ADD_DELAY=3, AND
    do_reset();
    drive(4'b1111, 4'b1111, 1'b1, MODE_AND, 1'b0);
    for (int c = 0; c < 5; c++) step();
    chk("pre_rst_ovf", c_ovf, 4'b1111);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_ovf",    c_ovf,    0);
    chk("rst_mid_sticky", c_sticky, 0);
    chk("rst_mid_any",    c_any,    0);
    chk("rst_mid_cnt",    c_cnt,    0);
    chk("rst_mid_irq",    c_irq,    0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("post_rst%0d_ovf", c), c_ovf, (c < 3) ? 4'b0000 : 4'b1111);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_overflow_monitor
